// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential arithmetic blocks (multiplier and divider).
package mul_pkg;

    localparam int MUL_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then arithmetic shift of {A,Q,q_1}.
// Purely combinational: zero latency, no flow control.
module booth_step
    import mul_pkg::*;
#(
    parameter int N = MUL_WIDTH
) (
    input  logic [N:0]   a,
    input  logic [N:0]   m,
    input  logic [N-1:0] q,
    input  logic         q_1,
    output logic [N:0]   a_nxt,
    output logic [N-1:0] q_nxt,
    output logic         q_1_nxt
);

    logic [N:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], q_1})
            BOOTH_ADD: sum = a + m;
            BOOTH_SUB: sum = a - m;
            default:   sum = a;
        endcase
    end

    assign a_nxt   = {sum[N], sum[N:1]};
    assign q_nxt   = {sum[0], q[N-1:1]};
    assign q_1_nxt = q[0];

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed Booth multiplier: N+2 cycles start-to-done (2 with BOOTH_ZERO_SKIP_EN on a zero operand).
// No queueing: start is only sampled in IDLE and ignored while busy or during the done cycle.
module booth_multiplier
    import mul_pkg::*;
#(
    parameter int N = MUL_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   mc_in,
    input  logic [N-1:0]   mp_in,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    state_t        state;
    logic [N:0]    a;
    logic [N:0]    m;
    logic [N-1:0]  q;
    logic          q_1;
    logic [CW-1:0] cnt;

    logic [N:0]    a_nxt;
    logic [N-1:0]  q_nxt;
    logic          q_1_nxt;
    logic          skip;

`ifdef BOOTH_ZERO_SKIP_EN
    assign skip = (mc_in == '0) || (mp_in == '0);
`else
    assign skip = 1'b0;
`endif

    booth_step #(.N(N)) u_step (
        .a       (a),
        .m       (m),
        .q       (q),
        .q_1     (q_1),
        .a_nxt   (a_nxt),
        .q_nxt   (q_nxt),
        .q_1_nxt (q_1_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a       <= '0;
            m       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // A is one bit wider than the operand so A-M cannot overflow for M = -2^(N-1)
                        m     <= {mc_in[N-1], mc_in};
                        a     <= '0;
                        q     <= skip ? '0 : mp_in;
                        q_1   <= 1'b0;
                        cnt   <= CW'(N);
                        busy  <= 1'b1;
                        state <= skip ? DONE : CALC;
                    end
                end
                CALC: begin
                    a   <= a_nxt;
                    q   <= q_nxt;
                    q_1 <= q_1_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    product <= {a[N-1:0], q};
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboarded bench for booth_multiplier at N=4; expected products come from integer multiplication.
module tb_booth_multiplier;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   mc_in = '0;
    logic [N-1:0]   mp_in = '0;
    logic [2*N-1:0] product;
    logic           busy;
    logic           done;

    int vectors = 0;
    int miscompares = 0;
    logic [2*N-1:0] sb[$];

    booth_multiplier #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mc_in   (mc_in),
        .mp_in   (mp_in),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse and record the reference product; returns after the sampling edge.
    task automatic issue(input int mc, input int mp);
        logic signed [N-1:0] mcs;
        logic signed [N-1:0] mps;
        int e;
        mcs   = N'(mc);
        mps   = N'(mp);
        e     = int'(mcs) * int'(mps);
        sb.push_back(e[2*N-1:0]);
        mc_in = mcs;
        mp_in = mps;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles from the start-sampling edge (counted as 1) until done, bounded.
    task automatic wait_done(output int lat, output int busy_cyc, output bit timeout);
        lat      = 1;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) busy_cyc++;
        end
        timeout = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({product, busy, done} !== {{2*N{1'b0}}, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_state: product=%h busy=%b done=%b, want 00 0 0", product, busy, done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, bc;
        bit to;
        logic [2*N-1:0] exp;
        issue(7, 2);
        wait_done(lat, bc, to);
        exp = sb.pop_front();
        vectors++;
        if (to || lat != N + 2) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d cycles (timeout=%0b), want %0d", lat, to, N + 2);
        end
        vectors++;
        if (bc != N + 1) begin
            miscompares++;
            $display("FAIL basic_busy_len: got %0d, want %0d", bc, N + 1);
        end
        vectors++;
        if (product !== exp || exp !== 8'h0E) begin
            miscompares++;
            $display("FAIL basic_product: got %h, want %h", product, exp);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_at_done: got %b, want 0", busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || product !== exp) begin
            miscompares++;
            $display("FAIL done_pulse_hold: done=%b product=%h, want 0 %h", done, product, exp);
        end
    endtask

    // Runs operand pairs back to back; product must hold its old value mid-operation.
    task automatic test_signs_and_margin();
        int pairs[5][2] = '{'{-5, 3}, '{3, -5}, '{-8, -8}, '{-8, 7}, '{-1, -1}};
        int lat, bc;
        bit to;
        logic [2*N-1:0] prev, exp;
        foreach (pairs[i]) begin
            prev = product;
            issue(pairs[i][0], pairs[i][1]);
            tick();
            vectors++;
            if (product !== prev) begin
                miscompares++;
                $display("FAIL hold_mid_op_%0d: got %h, want %h", i, product, prev);
            end
            wait_done(lat, bc, to);
            exp = sb.pop_front();
            vectors++;
            if (to || product !== exp) begin
                miscompares++;
                $display("FAIL product_%0d_x_%0d: got %h (timeout=%0b), want %h",
                         pairs[i][0], pairs[i][1], product, to, exp);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bc, extra;
        bit to;
        logic [2*N-1:0] exp;
        issue(7, 2);
        // New operands and start while busy must neither queue nor disturb the running multiply
        mc_in = 4'd3;
        mp_in = 4'd3;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_done(lat, bc, to);
        exp = sb.pop_front();
        vectors++;
        if (to || product !== exp) begin
            miscompares++;
            $display("FAIL busy_ignore_product: got %h (timeout=%0b), want %h", product, to, exp);
        end
        extra = 0;
        repeat (10) begin
            tick();
            if (done) extra++;
        end
        vectors++;
        if (extra != 0 || product !== exp) begin
            miscompares++;
            $display("FAIL busy_ignore_pulses: extra done=%0d product=%h, want 0 %h", extra, product, exp);
        end
    endtask

    task automatic test_midop_reset();
        int lat, bc, seen;
        bit to;
        logic [2*N-1:0] exp;
        issue(5, 5);
        void'(sb.pop_back());
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({product, busy, done} !== {{2*N{1'b0}}, 2'b00}) begin
            miscompares++;
            $display("FAIL midop_reset: product=%h busy=%b done=%b, want 00 0 0", product, busy, done);
        end
        seen = 0;
        repeat (8) begin
            tick();
            if (done || busy) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL midop_abandon: activity on %0d cycles, want 0", seen);
        end
        issue(6, -1);
        wait_done(lat, bc, to);
        exp = sb.pop_front();
        vectors++;
        if (to || product !== exp || exp !== 8'hFA) begin
            miscompares++;
            $display("FAIL after_reset_product: got %h (timeout=%0b), want %h", product, to, exp);
        end
        tick();
    endtask

    task automatic test_zero();
        int lat, bc, want_lat;
        bit to;
        logic [2*N-1:0] exp;
`ifdef BOOTH_ZERO_SKIP_EN
        want_lat = 2;
`else
        want_lat = N + 2;
`endif
        issue(0, 5);
        wait_done(lat, bc, to);
        exp = sb.pop_front();
        vectors++;
        if (to || lat != want_lat) begin
            miscompares++;
            $display("FAIL zero_latency: got %0d (timeout=%0b), want %0d", lat, to, want_lat);
        end
        vectors++;
        if (product !== exp) begin
            miscompares++;
            $display("FAIL zero_product: got %h, want %h", product, exp);
        end
        tick();
        issue(-3, 0);
        wait_done(lat, bc, to);
        exp = sb.pop_front();
        vectors++;
        if (to || lat != want_lat || product !== exp) begin
            miscompares++;
            $display("FAIL zero_mp: lat=%0d product=%h, want %0d %h", lat, product, want_lat, exp);
        end
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_signs_and_margin();
        test_busy_ignore();
        test_midop_reset();
        test_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Sequential signed radix-2 Booth multiplier: the multiply counterpart to the team's restoring divider.
- Shares that divider's operand width, clock/reset naming and one-step-per-clock style.
- Takes two N-bit two's-complement operands and produces a 2N-bit signed product after N iteration cycles.
- Uses a start/busy/done handshake so a controller or bench can sequence multiply and divide back to back.

Parameters:
- N, 4, operand width in bits (N >= 2); the product is 2N bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- mc_in  input  N  signed multiplicand.
- mp_in  input  N  signed multiplier.
- product  output  2N  signed result; holds its value until the next accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when product is valid.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; product=0, busy=0, done=0; internal registers cleared.
  - Reset overrides every other input, including mid-operation: any operation in flight is abandoned with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1, latch the operands: M=mc_in sign-extended to N+1 bits; A=0 (N+1 bits); Q=mp_in; q_1=0; cnt=N.
  - Next state is CALC, busy=1.
  - Otherwise remain in IDLE.
- CALC, one Booth step per cycle:
  - Examine {Q[0], q_1}: 01 gives A=A+M; 10 gives A=A-M; 00 and 11 leave A unchanged.
  - Then arithmetic right shift of {A,Q,q_1} by 1, with A's MSB replicated.
  - cnt decrements each step. After the step with cnt=1, the next state is DONE.
- DONE (exactly one cycle):
  - product={A[N-1:0],Q}, done=1, busy=0.
  - Next state is IDLE. done deasserts on the following cycle.
- Latency: start is sampled at edge k; done is high in the cycle after edge k+N+1. An accepted start gives done N+2 cycles later.
- start while busy or in DONE is ignored. There is no queueing.
- Width rule: A is N+1 bits so that A-M with M=-2^(N-1) cannot overflow. The product range is always representable in 2N bits; -2^(N-1) times -2^(N-1) gives +2^(2N-2).
- Operands are captured at start only. Changing mc_in/mp_in during CALC has no effect.
- product is not updated until DONE. Between operations it holds the last result.

Optional Feature:
- Macro: BOOTH_ZERO_SKIP_EN.
- When defined: if mc_in==0 or mp_in==0 at start, IDLE goes directly to DONE with product=0. Latency is then 2 cycles from start to done.
- When undefined: all operands take the full N CALC cycles. Results are identical in both builds; only timing differs.

Decomposition:
- Package mul_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - Booth pair encodings (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10);
  - the default width constant shared with the divider.
- One natural sub-module, booth_step: a purely combinational add/sub plus arithmetic shift of {A,Q,q_1} given M. booth_multiplier instantiates it once and holds the registers, counter and FSM.

Test Plan:
- N=4, mc=7, mp=2, start pulse -> done after 6 cycles, product=14 (8'h0E), busy high for 5 cycles.
- mc=-5 (4'b1011), mp=3 -> product=-15 (8'hF1). Then mc=3, mp=-5 -> same product.
- mc=-8, mp=-8 -> product=64 (8'h40). mc=-8, mp=7 -> product=-56 (8'hC8). This exercises the A overflow margin.
- start reasserted with new operands while busy -> ignored: the first result is unchanged and there is only one done pulse.
- rst=1 in the 3rd CALC cycle -> next cycle state=IDLE, product=0, busy=0, no done. A subsequent 6x(-1) gives -6.
- mc=0, mp=5 -> product=0. done arrives 6 cycles after start without BOOTH_ZERO_SKIP_EN, and 2 cycles after start with it.
